// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: on contention the requester that
// was not granted last time wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_gnt_idx,
  output logic       o_valid
);

  always_comb begin
    o_valid   = |i_req;
    o_gnt_idx = i_req[1];
    if (i_req == 2'b11) begin
      o_gnt_idx = ~i_last_grant;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer for the shared single-port memory:
// IDLE -> ISSUE -> WAIT -> ACK, one transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W,
  parameter int CNT_W  = mem_arb_pkg::CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_rw_en,
  input  logic [DATA_W-1:0] mem_data_read,
  output logic              busy,
  output logic              gnt_id,
  output logic [CNT_W-1:0]  xfer_cnt
);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic              w_arb_valid;
  logic              w_gnt_idx;
  logic              r_last_grant;
  logic              r_gnt_id;
  logic              r_we_q;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic [DATA_W-1:0] r_rd_data;
  logic [CNT_W-1:0]  r_xfer_cnt;

  rr_arb2 u_rr_arb2 (
    .i_req        (req),
    .i_last_grant (r_last_grant),
    .o_gnt_idx    (w_gnt_idx),
    .o_valid      (w_arb_valid)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ack, mem_rw_en and busy decode from the state register alone, so an
  // asynchronous reset clears them immediately.
  always_comb begin
    w_state_next = r_state;
    ack          = 2'b00;
    mem_rw_en    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_arb_valid) begin
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_rw_en    = r_we_q;
        w_state_next = WAIT;
      end
      WAIT: begin
        w_state_next = ACK;
      end
      ACK: begin
        ack[r_gnt_id] = 1'b1;
        w_state_next  = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last_grant <= 1'b1;
      r_gnt_id     <= 1'b0;
      r_we_q       <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_rd_data    <= '0;
      r_xfer_cnt   <= '0;
    end else begin
      if (r_state == IDLE && w_arb_valid) begin
        r_gnt_id     <= w_gnt_idx;
        r_last_grant <= w_gnt_idx;
        r_we_q       <= we[w_gnt_idx];
        r_mem_addr   <= w_gnt_idx ? addr1 : addr0;
        r_mem_data   <= w_gnt_idx ? wdata1 : wdata0;
      end
      // Memory output is registered, so the read byte is only valid in WAIT.
      if (r_state == WAIT && !r_we_q) begin
        r_rd_data <= mem_data_read;
      end
      if (r_state == ACK && r_xfer_cnt != {CNT_W{1'b1}}) begin
        r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign gnt_id   = r_gnt_id;
  assign xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 128x8 registered-read memory.
module tb_mem_arbiter;

  logic       CLK;
  logic       RST;
  logic [1:0] req;
  logic [1:0] we;
  logic [6:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic [1:0] ack;
  logic [7:0] rd_data;
  logic [6:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_rw_en;
  logic [7:0] mem_data_read;
  logic       busy;
  logic       gnt_id;
  logic [15:0] xfer_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:127];

  logic [6:0] cont_addr [4] = '{7'h10, 7'h20, 7'h11, 7'h22};
  logic [7:0] cont_data [4] = '{8'h31, 8'h42, 8'h33, 8'h44};

  mem_arbiter dut (
    .CLK           (CLK),
    .RST           (RST),
    .req           (req),
    .we            (we),
    .addr0         (addr0),
    .addr1         (addr1),
    .wdata0        (wdata0),
    .wdata1        (wdata1),
    .ack           (ack),
    .rd_data       (rd_data),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_rw_en     (mem_rw_en),
    .mem_data_read (mem_data_read),
    .busy          (busy),
    .gnt_id        (gnt_id),
    .xfer_cnt      (xfer_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: write and read capture at the same edge, registered read data.
  always @(posedge CLK) begin
    if (mem_rw_en) mem[mem_addr] <= mem_data;
    mem_data_read <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction from an idle arbiter; returns rd_data seen in the ack cycle.
  task automatic run_txn(input int id, input logic w, input logic [6:0] a,
                         input logic [7:0] d, output logic [7:0] rd);
    int k;
    int wr;
    k  = 0;
    wr = 0;
    if (id == 0) begin addr0 = a; wdata0 = d; end
    else begin addr1 = a; wdata1 = d; end
    we[id]  = w;
    req[id] = 1'b1;
    while (k < 8) begin
      @(negedge CLK);
      k++;
      if (mem_rw_en) wr++;
      if (ack != 2'b00) break;
    end
    chk("txn_latency", k, 3);
    chk("txn_ack", ack, (id == 0) ? 1 : 2);
    chk("txn_gnt_id", gnt_id, id);
    chk("txn_mem_addr", mem_addr, a);
    chk("txn_mem_data", mem_data, d);
    chk("txn_wr_pulses", wr, w);
    rd = rd_data;
    $display("txn id=%0d we=%0b addr=%02h wdata=%02h rd_data=%02h lat=%0d", id, w, a, d, rd_data, k);
    req[id] = 1'b0;
    @(negedge CLK);
    chk("txn_busy_after", busy, 0);
  endtask

  initial begin
    logic [7:0] rd;
    int n;
    int pulses;
    int last_k;
    int k_ack0;
    int k_ack1;
    int exp_id;

    RST = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge CLK);

    chk("rst_ack", ack, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_mem_rw_en", mem_rw_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    RST = 1'b0;

    // Single write then read
    run_txn(0, 1'b1, 7'h05, 8'hA5, rd);
    chk("wr_xfer_cnt", xfer_cnt, 1);
    run_txn(0, 1'b0, 7'h05, 8'h00, rd);
    chk("rd_data_a5", rd, 8'hA5);
    chk("rd_xfer_cnt", xfer_cnt, 2);

    // Contention from reset: grants alternate 0,1,0,1
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    we = 2'b11;
    addr0 = 7'h10; wdata0 = 8'h31;
    addr1 = 7'h20; wdata1 = 8'h42;
    req = 2'b11;
    n = 0; pulses = 0; last_k = 0;
    for (int k = 1; k <= 30 && n < 4; k++) begin
      @(negedge CLK);
      if (mem_rw_en) pulses++;
      if (ack != 2'b00) begin
        exp_id = n % 2;
        chk("cont_ack", ack, (exp_id == 0) ? 1 : 2);
        chk("cont_mem_addr", mem_addr, cont_addr[n]);
        chk("cont_mem_data", mem_data, cont_data[n]);
        if (n > 0) chk("cont_gap", k - last_k, 4);
        $display("contention ack=%02b mem_addr=%02h mem_data=%02h cycle=%0d", ack, mem_addr, mem_data, k);
        last_k = k;
        if (exp_id == 0) begin addr0 = 7'h11; wdata0 = 8'h33; end
        else begin addr1 = 7'h22; wdata1 = 8'h44; end
        n++;
        if (n == 4) req = 2'b00;
      end
    end
    chk("cont_count", n, 4);
    chk("cont_wr_pulses", pulses, 4);
    @(negedge CLK);
    chk("cont_xfer_cnt", xfer_cnt, 4);
    chk("cont_busy", busy, 0);

    // Late requester: req1 rises while requester 0 is in ISSUE
    addr0 = 7'h50; wdata0 = 8'h5A; we[0] = 1'b1; req[0] = 1'b1;
    @(negedge CLK);
    addr1 = 7'h10; we[1] = 1'b0; req[1] = 1'b1;
    k_ack0 = 0; k_ack1 = 0;
    for (int k = 1; k <= 10 && k_ack1 == 0; k++) begin
      @(negedge CLK);
      if (ack[0]) begin
        k_ack0 = k;
        req[0] = 1'b0;
      end
      if (ack[1]) begin
        k_ack1 = k;
        chk("late_ack1_only", ack, 2'b10);
        chk("late_rd_data", rd_data, 8'h31);
        req[1] = 1'b0;
      end
    end
    $display("late requester ack0_cycle=%0d ack1_cycle=%0d", k_ack0, k_ack1);
    chk("late_ack0_cycle", k_ack0, 2);
    chk("late_ack1_cycle", k_ack1, 6);
    @(negedge CLK);

    // Boundary addresses
    run_txn(0, 1'b1, 7'h7F, 8'hFF, rd);
    run_txn(1, 1'b1, 7'h00, 8'h01, rd);
    run_txn(0, 1'b0, 7'h7F, 8'h00, rd);
    chk("bnd_rd_127", rd, 8'hFF);
    run_txn(1, 1'b1, 7'h40, 8'h77, rd);
    chk("bnd_rd_hold_on_write", rd, 8'hFF);
    run_txn(1, 1'b0, 7'h00, 8'h00, rd);
    chk("bnd_rd_0", rd, 8'h01);

    // Reset during WAIT of a read
    addr0 = 7'h05; we[0] = 1'b0; req[0] = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rstw_busy_before", busy, 1);
    RST = 1'b1;
    #1;
    chk("rstw_ack", ack, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_rd_data", rd_data, 0);
    chk("rstw_mem_addr", mem_addr, 0);
    chk("rstw_mem_data", mem_data, 0);
    chk("rstw_mem_rw_en", mem_rw_en, 0);
    chk("rstw_gnt_id", gnt_id, 0);
    chk("rstw_xfer_cnt", xfer_cnt, 0);
    req = 2'b00;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (ack != 2'b00) n++;
    end
    chk("rstw_no_ack", n, 0);
    RST = 1'b0;
    we = 2'b00; addr0 = 7'h05; addr1 = 7'h7F;
    req = 2'b11;
    k_ack0 = 0;
    for (int k = 1; k <= 8 && k_ack0 == 0; k++) begin
      @(negedge CLK);
      if (ack != 2'b00) begin
        k_ack0 = k;
        chk("rstw_first_grant", ack, 2'b01);
        req = 2'b00;
      end
    end
    $display("after reset first ack cycle=%0d", k_ack0);
    chk("rstw_first_latency", k_ack0, 3);
    @(negedge CLK);

    // Counter saturation
    force dut.r_xfer_cnt = 16'hFFFE;
    #1;
    release dut.r_xfer_cnt;
    @(negedge CLK);
    chk("sat_preload", xfer_cnt, 16'hFFFE);
    run_txn(0, 1'b1, 7'h01, 8'h11, rd);
    chk("sat_cnt_1", xfer_cnt, 16'hFFFF);
    run_txn(1, 1'b1, 7'h02, 8'h22, rd);
    chk("sat_cnt_2", xfer_cnt, 16'hFFFF);
    run_txn(0, 1'b0, 7'h01, 8'h00, rd);
    chk("sat_cnt_3", xfer_cnt, 16'hFFFF);
    chk("sat_rd", rd, 8'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
